uart_tx: RTL and testbench

//  Serial UART transmitter; the transmit end of the 16x-oversampled link whose receive end is uart_rx.

---
 rtl/uart_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 16x-oversampled UART transmitter with a one-byte holding register
//            for back-to-back frames. Define UART_TX_PARITY_EN to add a parity bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  localparam logic [4:0] c_bit_last  = 5'd15;
  localparam logic [4:0] c_stop_last = 5'(SB_TICK - 1);
  localparam logic [2:0] c_n_last    = 3'(DBIT - 1);

  generate
    if (DBIT < 5 || DBIT > 8) begin : g_bad_dbit
      $error("uart_tx: DBIT must be in 5..8");
    end
    if (SB_TICK < 16 || SB_TICK > 32) begin : g_bad_sb_tick
      $error("uart_tx: SB_TICK must be in 16..32");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        tx_q, tx_d;
  logic        w_accept;
  logic        w_direct;

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] c_data_mask = 8'((1 << DBIT) - 1);
  logic par_q, par_d;
  logic w_din_par, w_hold_par;
  assign w_din_par  = ^(din & c_data_mask) ^ 1'(PARITY_ODD);
  assign w_hold_par = ^(hold_q & c_data_mask) ^ 1'(PARITY_ODD);
`endif

  assign tx_ready = ~hold_vld_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign w_accept = tx_start & ~hold_vld_q;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    tx_done_tick = 1'b0;
    w_direct     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          w_direct = 1'b1;
          state_d  = ST_START;
          s_d      = 5'd0;
          b_d      = din;
`ifdef UART_TX_PARITY_EN
          par_d    = w_din_par;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == c_bit_last) begin
            state_d = ST_DATA;
            s_d     = 5'd0;
            n_d     = 3'd0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == c_bit_last) begin
            s_d = 5'd0;
            b_d = b_q >> 1;
            if (n_q == c_n_last) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == c_bit_last) begin
            state_d = ST_STOP;
            s_d     = 5'd0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == c_stop_last) begin
            tx_done_tick = 1'b1;
            s_d          = 5'd0;
            // A buffered byte wins; otherwise a same-cycle strobe starts the next frame directly.
            if (hold_vld_q) begin
              state_d    = ST_START;
              b_d        = hold_q;
              hold_vld_d = 1'b0;
`ifdef UART_TX_PARITY_EN
              par_d      = w_hold_par;
`endif
            end else if (w_accept) begin
              w_direct = 1'b1;
              state_d  = ST_START;
              b_d      = din;
`ifdef UART_TX_PARITY_EN
              par_d    = w_din_par;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_accept && !w_direct) begin
      hold_d     = din;
      hold_vld_d = 1'b1;
    end

    // The line is registered from the next state so it changes on the same edge as the FSM.
    tx_d = 1'b1;
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      s_q        <= 5'd0;
      n_q        <= 3'd0;
      b_q        <= 8'd0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// Testbench for uart_tx: reset, single frame, back-to-back, overrun, stop-edge start,
// mid-frame reset and loopback through a behavioural 16x receiver.
module tb_uart_tx;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int PODD    = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = 16 * (NB - 1) + SB_TICK;  // clocks per frame at one s_tick per clock

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_ready, tx_busy, tx_done_tick, tx;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 1;
  int rec_idx  = 4096;
  logic rec_tx[0:1023];
  logic rec_done[0:1023];
  logic rec_busy[0:1023];
  logic rec_ready[0:1023];

  logic       rx_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_state = 0;
  int         rx_s = 0;
  int         rx_n = 0;
  logic [7:0] rx_b = 8'h00;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (tick_div <= 1) s_tick = 1'b1;
      else begin
        cnt++;
        if (cnt >= tick_div) begin cnt = 0; s_tick = 1'b1; end
        else s_tick = 1'b0;
      end
    end
  end

  initial begin : recorder
    forever begin
      @(negedge clk);
      if (rec_idx >= 0 && rec_idx < 1024) begin
        rec_tx[rec_idx]    = tx;
        rec_done[rec_idx]  = tx_done_tick;
        rec_busy[rec_idx]  = tx_busy;
        rec_ready[rec_idx] = tx_ready;
      end
      if (rec_idx < 4096) rec_idx++;
    end
  end

  initial begin : rx_model
    forever begin
      @(negedge clk);
      if (!rx_en) rx_state = 0;
      else if (s_tick) begin
        case (rx_state)
          0: if (tx == 1'b0) begin rx_state = 1; rx_s = 0; end
          1: if (rx_s == 7) begin rx_s = 0; rx_n = 0; rx_state = 2; end else rx_s++;
          2: if (rx_s == 15) begin
               rx_s = 0;
               rx_b = {tx, rx_b[7:1]};
               if (rx_n == DBIT - 1) rx_state = (NB == 11) ? 3 : 4; else rx_n++;
             end else rx_s++;
          3: if (rx_s == 15) begin rx_s = 0; rx_state = 4; end else rx_s++;
          default: if (rx_s == SB_TICK - 1) begin rx_q.push_back(rx_b); rx_state = 0; end
                   else rx_s++;
        endcase
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents b for one clock; recording index 0 is the first cycle after acceptance.
  task automatic start_send(input logic [7:0] b);
    tx_start = 1'b1;
    din      = b;
    @(posedge clk); #1;
    tx_start = 1'b0;
    rec_idx  = 0;
  endtask

  function automatic logic [15:0] seg(input int base);
    logic [15:0] v;
    for (int m = 0; m < 16; m++) v[m] = rec_tx[base + m];
    return v;
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DBIT) return b[k - 1];
    if (NB == 11 && k == DBIT + 1) return (^b) ^ 1'(PODD);
    return 1'b1;
  endfunction

  function automatic int cnt(input int which, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi; i++) begin
      case (which)
        0: c += (rec_done[i] === 1'b1) ? 1 : 0;
        1: c += (rec_busy[i] === 1'b1) ? 1 : 0;
        2: c += (rec_ready[i] === 1'b0) ? 1 : 0;
        default: c += (rec_tx[i] === 1'b1) ? 1 : 0;
      endcase
    end
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tx_start = ~tx_start;
      din = 8'hA5;
      @(negedge clk);
      n_checks++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b expected 1100", i,
                 {tx, tx_ready, tx_busy, tx_done_tick});
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tx_start = 1'b0;
    clk_wait(3);
    n_checks++;
    if ({tx, tx_ready, tx_busy, tx_done_tick} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 1100", {tx, tx_ready, tx_busy, tx_done_tick});
    end
  endtask

  task automatic test_single();
    start_send(8'h55);
    clk_wait(FR + 2);
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (seg(16 * k) !== {16{exp_bit(8'h55, k)}}) begin
        n_fail++;
        $display("FAIL single_bit %0d: got %h expected %h", k, seg(16 * k), {16{exp_bit(8'h55, k)}});
      end
    end
    n_checks++;
    if (cnt(0, 0, FR + 2) !== 1 || rec_done[FR - 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got count %0d at-end %b expected 1 and 1",
               cnt(0, 0, FR + 2), rec_done[FR - 1]);
    end
    n_checks++;
    if (cnt(1, 0, FR + 2) !== FR || rec_busy[FR] !== 1'b0 || rec_tx[FR] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: got %0d clks busy, tx after %b expected %0d and 1",
               cnt(1, 0, FR + 2), rec_tx[FR], FR);
    end
  endtask

  task automatic test_back_to_back();
    start_send(8'hA3);
    clk_wait(5);
    tx_start = 1'b1; din = 8'h0F;
    clk_wait(1);
    tx_start = 1'b0;
    clk_wait(2 * FR + 4 - 6);
    n_checks++;
    if (rec_ready[5] !== 1'b1 || cnt(2, 6, FR) !== FR - 6 || rec_ready[FR] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got before %b low-clks %0d after %b expected 1 %0d 1",
               rec_ready[5], cnt(2, 6, FR), rec_ready[FR], FR - 6);
    end
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (seg(16 * k) !== {16{exp_bit(8'hA3, k)}} || seg(FR + 16 * k) !== {16{exp_bit(8'h0F, k)}}) begin
        n_fail++;
        $display("FAIL b2b_bit %0d: got %h/%h expected %h/%h", k, seg(16 * k), seg(FR + 16 * k),
                 {16{exp_bit(8'hA3, k)}}, {16{exp_bit(8'h0F, k)}});
      end
    end
    n_checks++;
    if (cnt(0, 0, 2 * FR + 4) !== 2 || rec_done[FR - 1] !== 1'b1 || rec_done[2 * FR - 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses expected 2 at %0d and %0d",
               cnt(0, 0, 2 * FR + 4), FR - 1, 2 * FR - 1);
    end
    n_checks++;
    if (cnt(1, 0, 2 * FR + 4) !== 2 * FR || rec_tx[2 * FR] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0d busy clks expected %0d", cnt(1, 0, 2 * FR + 4), 2 * FR);
    end
  endtask

  task automatic test_overrun();
    start_send(8'hA3);
    clk_wait(5);
    tx_start = 1'b1; din = 8'h0F;
    clk_wait(1);
    tx_start = 1'b0;
    clk_wait(43);
    tx_start = 1'b1; din = 8'hFF;
    clk_wait(1);
    tx_start = 1'b0;
    clk_wait(3 * FR + 2 - 50);
    n_checks++;
    if (rec_ready[49] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_ready: got %b expected 0", rec_ready[49]);
    end
    for (int k = 1; k <= DBIT; k++) begin
      n_checks++;
      if (seg(16 * k) !== {16{exp_bit(8'hA3, k)}} || seg(FR + 16 * k) !== {16{exp_bit(8'h0F, k)}}) begin
        n_fail++;
        $display("FAIL overrun_data %0d: got %h/%h expected %h/%h", k, seg(16 * k), seg(FR + 16 * k),
                 {16{exp_bit(8'hA3, k)}}, {16{exp_bit(8'h0F, k)}});
      end
    end
    n_checks++;
    if (cnt(0, 0, 3 * FR + 2) !== 2 || cnt(1, 2 * FR, 3 * FR) !== 0 || cnt(3, 2 * FR, 3 * FR) !== FR) begin
      n_fail++;
      $display("FAIL overrun_third: got done %0d busy %0d high %0d expected 2 0 %0d",
               cnt(0, 0, 3 * FR + 2), cnt(1, 2 * FR, 3 * FR), cnt(3, 2 * FR, 3 * FR), FR);
    end
  endtask

  task automatic test_stop_direct();
    start_send(8'h55);
    clk_wait(FR - 1);
    tx_start = 1'b1; din = 8'h96;
    clk_wait(1);
    tx_start = 1'b0;
    clk_wait(FR + 4);
    n_checks++;
    if (rec_ready[FR - 1] !== 1'b1 || rec_done[FR - 1] !== 1'b1 || rec_ready[FR] !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_ready: got %b%b%b expected 111", rec_ready[FR - 1], rec_done[FR - 1], rec_ready[FR]);
    end
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (seg(FR + 16 * k) !== {16{exp_bit(8'h96, k)}}) begin
        n_fail++;
        $display("FAIL direct_bit %0d: got %h expected %h", k, seg(FR + 16 * k), {16{exp_bit(8'h96, k)}});
      end
    end
    n_checks++;
    if (cnt(0, 0, 2 * FR + 4) !== 2 || rec_busy[2 * FR] !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_end: got %0d pulses busy %b expected 2 and 0", cnt(0, 0, 2 * FR + 4), rec_busy[2 * FR]);
    end
  endtask

  task automatic test_reset_midframe();
    start_send(8'h3C);
    clk_wait(20);
    tx_start = 1'b1; din = 8'h11;
    clk_wait(1);
    tx_start = 1'b0;
    clk_wait(19);
    reset = 1'b0;
    clk_wait(1);
    @(negedge clk);
    n_checks++;
    if (rec_busy[40] !== 1'b1 || rec_tx[40] !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_before: got busy %b tx %b expected 1 0", rec_busy[40], rec_tx[40]);
    end
    n_checks++;
    if ({tx, tx_ready, tx_busy, tx_done_tick} !== 4'b1100) begin
      n_fail++;
      $display("FAIL midframe_abort: got %b expected 1100", {tx, tx_ready, tx_busy, tx_done_tick});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    clk_wait(2);
    start_send(8'h81);
    clk_wait(FR + 20);
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (seg(16 * k) !== {16{exp_bit(8'h81, k)}}) begin
        n_fail++;
        $display("FAIL midframe_fresh_bit %0d: got %h expected %h", k, seg(16 * k), {16{exp_bit(8'h81, k)}});
      end
    end
    n_checks++;
    if (cnt(0, 0, FR + 20) !== 1 || rec_busy[FR] !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_hold_cleared: got %0d pulses busy %b expected 1 and 0",
               cnt(0, 0, FR + 20), rec_busy[FR]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    start_send(8'h07);
    clk_wait(FR + 2);
    n_checks++;
    if (seg(16 * (DBIT + 1)) !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL parity_bit: got %h expected ffff", seg(16 * (DBIT + 1)));
    end
  endtask
`endif

  task automatic test_loopback();
    logic [7:0] bytes[4];
    int budget;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A; bytes[3] = 8'hC3;
    tick_div = 5;
    rx_q.delete();
    rx_en = 1'b1;
    clk_wait(2);
    for (int i = 0; i < 4; i++) begin
      budget = 0;
      while (tx_ready !== 1'b1 && budget < 3000) begin clk_wait(1); budget++; end
      if (budget >= 3000) begin
        n_checks++; n_fail++;
        $display("FAIL loop_ready byte %0d: got tx_ready %b expected 1 within budget", i, tx_ready);
      end
      tx_start = 1'b1; din = bytes[i];
      clk_wait(1);
      tx_start = 1'b0;
    end
    budget = 0;
    while (rx_q.size() < 4 && budget < 6000) begin clk_wait(1); budget++; end
    n_checks++;
    if (rx_q.size() !== 4) begin
      n_fail++;
      $display("FAIL loop_count: got %0d bytes expected 4", rx_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== bytes[i]) begin
        n_fail++;
        $display("FAIL loop_byte %0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, bytes[i]);
      end
    end
    clk_wait(5 * SB_TICK + 20);
    rx_en = 1'b0;
    tick_div = 1;
    clk_wait(2);
  endtask

  initial begin
    test_reset();
    test_single();
    clk_wait(3);
    test_back_to_back();
    clk_wait(3);
    test_overrun();
    clk_wait(3);
    test_stop_direct();
    clk_wait(3);
    test_reset_midframe();
    clk_wait(3);
`ifdef UART_TX_PARITY_EN
    test_parity();
    clk_wait(3);
`endif
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
